// File: rtl/vga_timing_pkg.sv
// Shared raster constants and receiver FSM encoding for the TinyVGA PMOD receive path.
package vga_timing_pkg;

  localparam int H_START     = 144;
  localparam int H_ACTIVE    = 640;
  localparam int V_START     = 35;
  localparam int V_ACTIVE    = 480;
  localparam int H_TOTAL     = 800;
  localparam int V_TOTAL     = 525;
  localparam int LOCK_FRAMES = 2;
  localparam logic SYNC_POL  = 1'b0;

  localparam logic [9:0] H_START_C  = 10'(H_START);
  localparam logic [9:0] H_ACTIVE_C = 10'(H_ACTIVE);
  localparam logic [9:0] V_START_C  = 10'(V_START);
  localparam logic [9:0] V_ACTIVE_C = 10'(V_ACTIVE);
  localparam logic [9:0] H_MIN_C    = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] CNT_MAX    = 10'd1023;

  // LOCK_FRAMES identical measurements means LOCK_FRAMES-1 repeats of the first one.
  localparam logic [1:0] LOCK_REPEATS = 2'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_t;

  function automatic logic in_range(input logic [9:0] v, input logic [9:0] lo,
                                    input logic [9:0] len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers one sync pin and flags the cycle where it first shows the active level.
module sync_edge_det
  import vga_timing_pkg::*;
#(
  parameter logic POL = SYNC_POL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sync,
  output logic o_edge
);

  logic r_level;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_level <= i_sync;
      r_prev  <= r_level;
    end
  end

  assign o_edge = (r_level == POL) && (r_prev != POL);

endmodule

// File: rtl/vga_pmod_receiver.sv
// TinyVGA PMOD receiver: recovers sync timing, locks to the raster, regenerates
// pixel coordinates/colour two clocks after the pins and checksums each locked frame.
module vga_pmod_receiver
  import vga_timing_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  vga_in,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic        rx_active,
  output logic [1:0]  rx_r,
  output logic [1:0]  rx_g,
  output logic [1:0]  rx_b,
  output logic        locked,
  output logic [9:0]  h_total,
  output logic [9:0]  v_total,
  output logic [15:0] frame_sum,
  output logic        frame_done,
  output logic [1:0]  dbg_state
);

  logic        w_hs_edge;
  logic        w_vs_edge;
  logic [5:0]  r_col;
  logic [9:0]  r_hcnt;
  logic [9:0]  r_vcnt;
  logic [9:0]  r_h_total;
  logic [9:0]  r_v_total;
  logic [9:0]  r_prev_h;
  logic [9:0]  r_prev_v;
  logic [1:0]  r_match;
  logic [15:0] r_acc;
  logic [15:0] r_frame_sum;
  logic        r_frame_done;
  logic [9:0]  r_rx_x;
  logic [9:0]  r_rx_y;
  logic        r_rx_active;
  logic [5:0]  r_rx_col;
  rx_state_t   r_state;
  rx_state_t   w_state_nxt;
  logic [1:0]  w_match_nxt;
  logic [1:0]  w_match_inc;
  logic        w_frame_ok;
  logic [9:0]  w_hcnt_inc;
  logic [9:0]  w_vcnt_inc;
  logic [9:0]  w_hcnt;
  logic [9:0]  w_vcnt;
  logic        w_same;
  logic        w_active;

  sync_edge_det #(.POL(SYNC_POL)) u_hsync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sync (vga_in[7]),
    .o_edge (w_hs_edge)
  );

  sync_edge_det #(.POL(SYNC_POL)) u_vsync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sync (vga_in[3]),
    .o_edge (w_vs_edge)
  );

  // Colour kept as {R1,R0,G1,G0,B1,B0}, aligned with the registered syncs.
  always_ff @(posedge clk) begin
    if (!rst_n) r_col <= 6'd0;
    else        r_col <= {vga_in[0], vga_in[4], vga_in[1], vga_in[5], vga_in[2], vga_in[6]};
  end

  assign w_hcnt_inc = (r_hcnt == CNT_MAX) ? CNT_MAX : r_hcnt + 10'd1;
  assign w_vcnt_inc = (r_vcnt == CNT_MAX) ? CNT_MAX : r_vcnt + 10'd1;
  assign w_hcnt     = w_hs_edge ? 10'd0 : w_hcnt_inc;
  assign w_vcnt     = w_vs_edge ? 10'd0 : (w_hs_edge ? w_vcnt_inc : r_vcnt);
  assign w_same     = (r_h_total == r_prev_h) && (r_vcnt == r_prev_v);
  assign w_match_inc = r_match + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hcnt    <= 10'd0;
      r_vcnt    <= 10'd0;
      r_h_total <= 10'd0;
      r_v_total <= 10'd0;
      r_prev_h  <= 10'd0;
      r_prev_v  <= 10'd0;
    end else begin
      r_hcnt <= w_hcnt;
      r_vcnt <= w_vcnt;
      if (w_hs_edge) r_h_total <= w_hcnt_inc;
      if (w_vs_edge) begin
        r_v_total <= r_vcnt;
        r_prev_h  <= r_h_total;
        r_prev_v  <= r_vcnt;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match;
    w_frame_ok  = 1'b0;
    unique case (r_state)
      ST_SEARCH: begin
        if (w_vs_edge) begin
          w_state_nxt = ST_TRACK;
          w_match_nxt = 2'd0;
        end
      end
      ST_TRACK: begin
        if (w_vs_edge) begin
          if (w_same && (r_h_total >= H_MIN_C)) begin
            w_match_nxt = w_match_inc;
            if (w_match_inc >= LOCK_REPEATS) w_state_nxt = ST_LOCKED;
          end else begin
            w_match_nxt = 2'd0;
          end
        end
      end
      ST_LOCKED: begin
        if ((w_hs_edge && (w_hcnt_inc != r_h_total)) ||
            (w_vs_edge && (r_vcnt != r_v_total))) begin
          w_state_nxt = ST_SEARCH;
        end else if (w_vs_edge) begin
          w_frame_ok = 1'b1;
        end
      end
      default: w_state_nxt = ST_SEARCH;
    endcase
    // A missing hsync overrides everything: the raster is gone.
    if (w_hcnt == CNT_MAX) begin
      w_state_nxt = ST_SEARCH;
      w_frame_ok  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_SEARCH;
      r_match <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_match <= w_match_nxt;
    end
  end

  assign w_active = (r_state == ST_LOCKED) &&
                    in_range(w_hcnt, H_START_C, H_ACTIVE_C) &&
                    in_range(w_vcnt, V_START_C, V_ACTIVE_C);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_x      <= 10'd0;
      r_rx_y      <= 10'd0;
      r_rx_active <= 1'b0;
      r_rx_col    <= 6'd0;
    end else begin
      r_rx_active <= w_active;
      r_rx_x      <= w_active ? w_hcnt - H_START_C : 10'd0;
      r_rx_y      <= w_active ? w_vcnt - V_START_C : 10'd0;
      r_rx_col    <= w_active ? r_col : 6'd0;
    end
  end

  // Accumulator restarts every frame; only frames that stay locked are published.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc        <= 16'd0;
      r_frame_sum  <= 16'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_ok;
      if (w_frame_ok) r_frame_sum <= r_acc;
      if (w_vs_edge)     r_acc <= 16'd0;
      else if (w_active) r_acc <= r_acc + {10'd0, r_col};
    end
  end

  assign rx_x       = r_rx_x;
  assign rx_y       = r_rx_y;
  assign rx_active  = r_rx_active;
  assign rx_r       = r_rx_col[5:4];
  assign rx_g       = r_rx_col[3:2];
  assign rx_b       = r_rx_col[1:0];
  assign locked     = (r_state == ST_LOCKED);
  assign h_total    = r_h_total;
  assign v_total    = r_v_total;
  assign frame_sum  = r_frame_sum;
  assign frame_done = r_frame_done;
  assign dbg_state  = r_state;

endmodule
